// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled, mid-bit sampling, 8 data bits, 1 stop bit.
// Data bits may be inverted on the line; BIT_INVERT restores true polarity.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for synchronized low (start edge)
// START     | confirming start bit at its middle (8th tick)
// DATA      | sampling 8 data bits, one every 16 ticks, LSB first
// STOP      | sampling stop bit; high = good frame, low = framing error
// WAIT_IDLE | after framing error, wait for the line to return high
module uart_receiver #(
  parameter int OVERSAMPLE_DIV = 651,
  parameter bit BIT_INVERT     = 1'b1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       RX_ERR,
  output logic       busy
);

  localparam int DIV_W = (OVERSAMPLE_DIV > 1) ? $clog2(OVERSAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(OVERSAMPLE_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tick;
  logic             mid_tick;
  logic             full_tick;
  logic             start_ok;
  logic             shift_en;
  logic             frame_good;
  logic             frame_bad;

  // Two-flop synchronizer; idles high so reset does not look like a start edge
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
    end
  end

  assign tick      = (div_cnt == '0);
  assign mid_tick  = tick && (tick_cnt == 4'd7);
  assign full_tick = tick && (tick_cnt == 4'd15);

  // Tick divider: down-counter held at its load value in IDLE, so timing
  // restarts from zero exactly when START is entered
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (state == S_IDLE || tick) begin
      div_cnt <= DIV_LOAD;
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  // Tick counter: cleared in IDLE and again once the start bit is confirmed,
  // so data bits are sampled 16 ticks apart from the start-bit middle
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= 4'd0;
    end else if (state == S_IDLE || start_ok) begin
      tick_cnt <= 4'd0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 4'd1;
    end
  end

  // State register
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    shift_en   = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        if (mid_tick) begin
          if (!rx_s) begin
            start_ok   = 1'b1;
            state_next = S_DATA;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (full_tick) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (full_tick) begin
          if (rx_s) begin
            frame_good = 1'b1;
            state_next = S_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Shift register and bit index; bit index saturates at 7 (STOP follows)
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
    end else if (start_ok) begin
      bit_idx <= 3'd0;
    end else if (shift_en) begin
      shreg <= {rx_s ^ BIT_INVERT, shreg[7:1]};
      if (bit_idx != 3'd7) bit_idx <= bit_idx + 3'd1;
    end
  end

  // Registered outputs: pulses land the cycle after the stop-bit sample
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      RX_DATA   <= 8'h00;
      RX_STATUS <= 1'b0;
      RX_ERR    <= 1'b0;
    end else begin
      RX_STATUS <= frame_good;
      RX_ERR    <= frame_bad;
      if (frame_good) RX_DATA <= shreg;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
